// File: rtl/grid_mem_arbiter.sv
// Single-port grid RAM arbiter for the light-bike arena. Each cycle it grants
// one access to the VGA reader, the game engine or the border-rebuild sweep.
module grid_mem_arbiter #(
    parameter int GRID_SIZE     = 16,
    parameter int LOG_GRID_SIZE = 4,
    parameter int MAX_WAIT      = 8
) (
    input  logic                         board_clk,
    input  logic                         reset,
    input  logic                         vga_req,
    input  logic [2*LOG_GRID_SIZE-1:0]   vga_addr,
    output logic                         vga_rvalid,
    output logic                         vga_rdata,
    output logic                         vga_miss,
    input  logic                         eng_req,
    input  logic                         eng_we,
    input  logic [2*LOG_GRID_SIZE-1:0]   eng_addr,
    input  logic                         eng_wdata,
    output logic                         eng_gnt,
    output logic                         eng_rvalid,
    output logic                         eng_rdata,
    input  logic                         clear_start,
    output logic                         clear_busy,
    output logic                         clear_done,
    output logic [2*LOG_GRID_SIZE-1:0]   mem_addr,
    output logic                         mem_we,
    output logic                         mem_wdata,
    input  logic                         mem_rdata
);
    // state    | meaning
    // ST_IDLE  | no rebuild; VGA and engine share the RAM
    // ST_SWEEP | rebuilding the arena, one cell per cycle the sweep wins
    // ST_DONE  | one-cycle completion pulse, then back to idle

    localparam int AW = 2 * LOG_GRID_SIZE;
    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam logic [AW-1:0]            LAST_ADDR = AW'(GRID_SIZE * GRID_SIZE - 1);
    localparam logic [LOG_GRID_SIZE-1:0] EDGE      = LOG_GRID_SIZE'(GRID_SIZE - 1);
    localparam logic [WW-1:0]            WAIT_MAX  = WW'(MAX_WAIT);

    typedef enum logic [1:0] {ST_IDLE, ST_SWEEP, ST_DONE} clr_state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_VGA, OWN_ENG} owner_t;

    clr_state_t    state_q, state_d;
    owner_t        owner_q, owner_d;
    logic [AW-1:0] sweep_cnt_q, sweep_cnt_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [WW-1:0] wait_cnt_q, wait_cnt_d;

    logic in_sweep;
    logic eng_preempt;
    logic vga_win;
    logic eng_win;
    logic sweep_win;
    logic border_cell;
    logic mem_we_c;
    logic mem_wdata_c;

    always_comb begin
        in_sweep    = (state_q == ST_SWEEP);
        // A starved engine may jump the VGA, but never writes under a sweep.
        eng_preempt = !reset && eng_req && (wait_cnt_q == WAIT_MAX) && !(in_sweep && eng_we);
        vga_win     = !reset && vga_req && !eng_preempt;
        eng_win     = eng_preempt || (!reset && eng_req && !in_sweep && !vga_req);
        sweep_win   = !reset && in_sweep && !vga_req && !eng_preempt;

        border_cell = (sweep_cnt_q[LOG_GRID_SIZE-1:0] == '0) ||
                      (sweep_cnt_q[LOG_GRID_SIZE-1:0] == EDGE) ||
                      (sweep_cnt_q[AW-1:LOG_GRID_SIZE] == '0) ||
                      (sweep_cnt_q[AW-1:LOG_GRID_SIZE] == EDGE);

        mem_addr_d  = mem_addr_q;
        mem_we_c    = 1'b0;
        mem_wdata_c = 1'b0;
        owner_d     = OWN_NONE;
        if (vga_win) begin
            mem_addr_d = vga_addr;
            owner_d    = OWN_VGA;
        end else if (eng_win) begin
            mem_addr_d  = eng_addr;
            mem_we_c    = eng_we;
            mem_wdata_c = eng_we & eng_wdata;
            owner_d     = eng_we ? OWN_NONE : OWN_ENG;
        end else if (sweep_win) begin
            mem_addr_d  = sweep_cnt_q;
            mem_we_c    = 1'b1;
            mem_wdata_c = border_cell;
        end

        state_d     = state_q;
        sweep_cnt_d = sweep_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (clear_start) begin
                    state_d     = ST_SWEEP;
                    sweep_cnt_d = '0;
                end
            end
            ST_SWEEP: begin
                if (sweep_win) begin
                    sweep_cnt_d = sweep_cnt_q + AW'(1);
                    if (sweep_cnt_q == LAST_ADDR) state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        wait_cnt_d = wait_cnt_q;
        if (!in_sweep) begin
            if (!eng_req || eng_win)       wait_cnt_d = '0;
            else if (wait_cnt_q != WAIT_MAX) wait_cnt_d = wait_cnt_q + WW'(1);
        end
    end

    always_ff @(posedge board_clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_NONE;
            sweep_cnt_q <= '0;
            mem_addr_q  <= '0;
            wait_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            sweep_cnt_q <= sweep_cnt_d;
            mem_addr_q  <= mem_addr_d;
            wait_cnt_q  <= wait_cnt_d;
        end
    end

    assign mem_addr   = mem_addr_d;
    assign mem_we     = mem_we_c;
    assign mem_wdata  = mem_wdata_c;
    assign eng_gnt    = eng_win;
    assign vga_miss   = !reset && vga_req && !vga_win;
    assign clear_busy = (state_q == ST_SWEEP);
    assign clear_done = (state_q == ST_DONE);
    assign vga_rvalid = (owner_q == OWN_VGA);
    assign eng_rvalid = (owner_q == OWN_ENG);
    assign vga_rdata  = vga_rvalid & mem_rdata;
    assign eng_rdata  = eng_rvalid & mem_rdata;

endmodule

// File: tb/tb_grid_mem_arbiter.sv
// Directed/randomized bench for grid_mem_arbiter with a behavioural RAM and a
// grid-level reference model of what each cell should hold.
module tb_grid_mem_arbiter;
    localparam int G  = 16;
    localparam int L  = 4;
    localparam int MW = 8;
    localparam int N  = G * G;

    logic         board_clk = 1'b0;
    logic         reset;
    logic         vga_req;
    logic [2*L-1:0] vga_addr;
    logic         vga_rvalid, vga_rdata, vga_miss;
    logic         eng_req, eng_we, eng_wdata;
    logic [2*L-1:0] eng_addr;
    logic         eng_gnt, eng_rvalid, eng_rdata;
    logic         clear_start, clear_busy, clear_done;
    logic [2*L-1:0] mem_addr;
    logic         mem_we, mem_wdata, mem_rdata;

    grid_mem_arbiter #(.GRID_SIZE(G), .LOG_GRID_SIZE(L), .MAX_WAIT(MW)) dut (
        .board_clk(board_clk), .reset(reset),
        .vga_req(vga_req), .vga_addr(vga_addr), .vga_rvalid(vga_rvalid),
        .vga_rdata(vga_rdata), .vga_miss(vga_miss),
        .eng_req(eng_req), .eng_we(eng_we), .eng_addr(eng_addr), .eng_wdata(eng_wdata),
        .eng_gnt(eng_gnt), .eng_rvalid(eng_rvalid), .eng_rdata(eng_rdata),
        .clear_start(clear_start), .clear_busy(clear_busy), .clear_done(clear_done),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 board_clk = ~board_clk;

    // Single-port RAM, one-cycle read latency, write-first.
    logic ram [N];
    logic ram_q;
    always @(posedge board_clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        ram_q <= mem_we ? mem_wdata : ram[mem_addr];
    end
    assign mem_rdata = ram_q;

    int errors = 0;
    int checks = 0;
    bit ref_grid [N];
    bit old_grid [N];

    function automatic bit border_of(input int a);
        int x, y;
        x = a % G;
        y = a / G;
        return (x == 0) || (x == G - 1) || (y == 0) || (y == G - 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge board_clk);
        #1;
    endtask

    task automatic samp();
        @(negedge board_clk);
    endtask

    task automatic idle_in();
        vga_req = 0; vga_addr = '0; eng_req = 0; eng_we = 0;
        eng_addr = '0; eng_wdata = 0; clear_start = 0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_vga_rvalid"}, vga_rvalid, 0);
        chk({tag, "_vga_rdata"},  vga_rdata, 0);
        chk({tag, "_vga_miss"},   vga_miss, 0);
        chk({tag, "_eng_gnt"},    eng_gnt, 0);
        chk({tag, "_eng_rvalid"}, eng_rvalid, 0);
        chk({tag, "_eng_rdata"},  eng_rdata, 0);
        chk({tag, "_clear_busy"}, clear_busy, 0);
        chk({tag, "_clear_done"}, clear_done, 0);
        chk({tag, "_mem_addr"},   mem_addr, 0);
        chk({tag, "_mem_we"},     mem_we, 0);
        chk({tag, "_mem_wdata"},  mem_wdata, 0);
    endtask

    // Full sweep with no competing traffic: one write per cycle in address order.
    task automatic do_clear();
        clear_start = 1;
        samp();
        chk("clr_busy_before", clear_busy, 0);
        tick();
        clear_start = 0;
        for (int k = 0; k < N; k++) begin
            samp();
            chk("clr_busy", clear_busy, 1);
            chk("clr_we", mem_we, 1);
            chk("clr_addr", mem_addr, k);
            chk("clr_wdata", mem_wdata, border_of(k));
            tick();
        end
        samp();
        chk("clr_done", clear_done, 1);
        chk("clr_busy_end", clear_busy, 0);
        chk("clr_idle_we", mem_we, 0);
        chk("clr_addr_hold", mem_addr, N - 1);
        tick();
        samp();
        chk("clr_done_pulse", clear_done, 0);
        tick();
        for (int a = 0; a < N; a++) ref_grid[a] = border_of(a);
    endtask

    task automatic vga_read(input int a);
        vga_req = 1;
        vga_addr = a[2*L-1:0];
        samp();
        chk("vga_rd_miss", vga_miss, 0);
        tick();
        vga_req = 0;
        samp();
        chk("vga_rd_rvalid", vga_rvalid, 1);
        chk("vga_rd_data", vga_rdata, ref_grid[a]);
        chk("vga_rd_eng_rvalid", eng_rvalid, 0);
        tick();
    endtask

    task automatic eng_op(input bit we, input int a, input bit d);
        bit got;
        got = 0;
        eng_req = 1; eng_we = we; eng_addr = a[2*L-1:0]; eng_wdata = d;
        for (int n = 0; n < 20 && !got; n++) begin
            samp();
            if (eng_gnt) got = 1;
            else tick();
        end
        chk("eng_op_gnt", got, 1);
        if (got) tick();
        eng_req = 0;
        samp();
        chk("eng_op_rvalid", eng_rvalid, !we);
        if (!we) chk("eng_op_rdata", eng_rdata, ref_grid[a]);
        else ref_grid[a] = d;
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int a, k, a7, pva, pea;
        bit prev_vg, prev_eg, exp_pre, fin, bad, exp_prev;

        // Reset state
        reset = 1;
        idle_in();
        tick();
        tick();
        samp();
        check_all_zero("rst");
        tick();
        reset = 0;
        tick();

        // Clean arena rebuild and readback
        do_clear();
        vga_read(0 * G + 5);
        vga_read(15 * G + 3);
        vga_read(5 * G + 0);
        vga_read(7 * G + 7);

        // Engine write then read of the same cell on consecutive grants
        a = 8 * G + 4;
        eng_req = 1; eng_we = 1; eng_addr = a[2*L-1:0]; eng_wdata = 1;
        samp();
        chk("wr84_gnt", eng_gnt, 1);
        chk("wr84_mem_we", mem_we, 1);
        tick();
        ref_grid[a] = 1;
        eng_we = 0;
        samp();
        chk("rd84_gnt", eng_gnt, 1);
        chk("wr84_no_rvalid", eng_rvalid, 0);
        tick();
        eng_req = 0;
        samp();
        chk("rd84_rvalid", eng_rvalid, 1);
        chk("rd84_rdata", eng_rdata, 1);
        tick();

        // Random engine traffic: dirty some interior cells, read some back
        for (int i = 0; i < 10; i++) begin
            a = $urandom_range(1, G - 2) * G + $urandom_range(1, G - 2);
            if (i < 6) eng_op(1, a, 1);
            else       eng_op(0, $urandom % N, 0);
        end

        // VGA saturating the port: engine preempts after MW denials
        idle_in();
        tick();
        prev_vg = 0; prev_eg = 0; pva = 0; pea = 0;
        vga_req = 1; eng_req = 1; eng_we = 0;
        eng_addr = 8'($urandom % N);
        for (int i = 0; i < 3 * (MW + 1); i++) begin
            vga_addr = 8'($urandom % N);
            samp();
            exp_pre = ((i % (MW + 1)) == MW);
            chk("sat_eng_gnt", eng_gnt, exp_pre);
            chk("sat_vga_miss", vga_miss, exp_pre);
            chk("sat_vga_rvalid", vga_rvalid, prev_vg);
            if (prev_vg) chk("sat_vga_rdata", vga_rdata, ref_grid[pva]);
            chk("sat_eng_rvalid", eng_rvalid, prev_eg);
            if (prev_eg) chk("sat_eng_rdata", eng_rdata, ref_grid[pea]);
            prev_vg = !exp_pre; pva = vga_addr;
            prev_eg = exp_pre;  pea = eng_addr;
            tick();
            if (exp_pre) eng_addr = 8'($urandom % N);
        end
        idle_in();
        samp();
        chk("sat_tail_eng_rvalid", eng_rvalid, 1);
        chk("sat_tail_eng_rdata", eng_rdata, ref_grid[pea]);
        chk("sat_tail_vga_rvalid", vga_rvalid, 0);
        tick();

        // VGA on every other cycle of a sweep: sweep stalls, reads see a half-rebuilt grid
        for (int i = 0; i < N; i++) old_grid[i] = ref_grid[i];
        clear_start = 1;
        samp();
        tick();
        clear_start = 0;
        k = 0; fin = 0; prev_vg = 0; exp_prev = 0;
        while (!fin && k < 1200) begin
            vga_req = (k % 2 == 0);
            vga_addr = 8'($urandom % N);
            samp();
            if (!clear_busy) begin
                fin = 1;
            end else begin
                chk("mix_vga_miss", vga_miss, 0);
                chk("mix_mem_we", mem_we, (k % 2 == 1));
                if (k % 2 == 1) chk("mix_sweep_addr", mem_addr, (k - 1) / 2);
                chk("mix_vga_rvalid", vga_rvalid, prev_vg);
                if (prev_vg) chk("mix_vga_rdata", vga_rdata, exp_prev);
                if (vga_req) begin
                    a = int'(vga_addr);
                    exp_prev = (a < k / 2) ? border_of(a) : old_grid[a];
                end
                prev_vg = vga_req;
                tick();
                k++;
            end
        end
        chk("mix_sweep_cycles", k, 2 * N);
        chk("mix_done", clear_done, 1);
        chk("mix_done_rvalid", vga_rvalid, prev_vg);
        a = int'(vga_addr);
        tick();
        idle_in();
        for (int i = 0; i < N; i++) ref_grid[i] = border_of(i);
        samp();
        chk("mix_post_rvalid", vga_rvalid, 1);
        chk("mix_post_rdata", vga_rdata, ref_grid[a]);
        tick();

        // Engine write pending across a sweep: wait count frozen, no preempt
        a7 = 3 * G + 9;
        eng_req = 1; eng_we = 1; eng_addr = a7[2*L-1:0]; eng_wdata = 1;
        vga_req = 1;
        for (int c = 0; c < 6; c++) begin
            vga_addr = 8'($urandom % N);
            clear_start = (c == 5);
            samp();
            chk("frz_pre_gnt", eng_gnt, 0);
            chk("frz_pre_miss", vga_miss, 0);
            tick();
        end
        clear_start = 0;
        vga_req = 0;
        for (int n = 0; n < N; n++) begin
            samp();
            chk("frz_busy", clear_busy, 1);
            chk("frz_no_gnt", eng_gnt, 0);
            chk("frz_sweep_we", mem_we, 1);
            tick();
        end
        vga_req = 1;
        for (int n = 0; n < 3; n++) begin
            vga_addr = 8'($urandom % N);
            samp();
            if (n == 0) chk("frz_done", clear_done, 1);
            chk("frz_post_gnt", eng_gnt, (n == MW - 6));
            chk("frz_post_miss", vga_miss, (n == MW - 6));
            tick();
        end
        ref_grid[a7] = 1;
        idle_in();
        samp();
        chk("frz_wr_no_rvalid", eng_rvalid, 0);
        chk("frz_vga_rvalid", vga_rvalid, 0);
        tick();
        vga_read(a7);

        // Reset in the middle of a sweep
        clear_start = 1;
        samp();
        tick();
        clear_start = 0;
        for (int n = 0; n < 100; n++) tick();
        reset = 1;
        tick();
        samp();
        check_all_zero("midrst");
        tick();
        reset = 0;
        bad = 0;
        for (int n = 0; n < 300; n++) begin
            samp();
            if (clear_done || clear_busy) bad = 1;
            tick();
        end
        chk("midrst_no_done", bad, 0);
        do_clear();
        for (int i = 0; i < 8; i++) vga_read($urandom % N);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/grid_mem_arbiter.md
Name: grid_mem_arbiter

Overview:
- Owns the single-port grid RAM, a 1-bit cell per grid square, that holds the light-bike trails.
- Arbitrates one RAM access per cycle among three users: the VGA renderer (cell reads), the game engine (collision reads and trail writes), and a built-in clear sequencer.
- The clear sequencer rebuilds the arena at round start: border cells = 1, interior cells = 0.
- Sits between the game state machine, the pixel pipeline and the RAM instance.

Parameters:
- GRID_SIZE, 16: cells per side.
- LOG_GRID_SIZE, 4: bits per coordinate; GRID_SIZE = 2**LOG_GRID_SIZE.
- MAX_WAIT, 8: maximum consecutive cycles the engine may be denied by the VGA before it preempts.

Ports:
- board_clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- vga_req  in  1  renderer requests a cell read this cycle.
- vga_addr  in  2*LOG_GRID_SIZE  {y,x} of the cell.
- vga_rvalid  out  1  vga_rdata valid.
- vga_rdata  out  1  cell value.
- vga_miss  out  1  1-cycle pulse: this cycle's vga_req was not served.
- eng_req  in  1  engine access request; held until granted.
- eng_we  in  1  1 = write, 0 = read.
- eng_addr  in  2*LOG_GRID_SIZE  {y,x}.
- eng_wdata  in  1  write data.
- eng_gnt  out  1  access issued this cycle.
- eng_rvalid  out  1  eng_rdata valid.
- eng_rdata  out  1  read result.
- clear_start  in  1  pulse: begin an arena rebuild.
- clear_busy  out  1  sweep in progress.
- clear_done  out  1  1-cycle pulse when the sweep completes.
- mem_addr  out  2*LOG_GRID_SIZE  RAM address.
- mem_we  out  1  RAM write enable.
- mem_wdata  out  1  RAM write data.
- mem_rdata  in  1  RAM read data, valid one cycle after the address is issued.

Behaviour:
- Reset: all outputs 0, sweep counter 0, wait counter 0, read-owner register = NONE, clear FSM = IDLE.
- Clear FSM states and transitions:
  - IDLE -> SWEEP on clear_start.
  - SWEEP -> DONE after address GRID_SIZE*GRID_SIZE-1 is written.
  - DONE -> IDLE unconditionally. clear_done = 1 only in DONE.
- clear_busy = 1 in SWEEP.
- clear_start is ignored outside IDLE.
- Priority each cycle:
  1. Engine preempt: eng_req && wait_cnt == MAX_WAIT.
  2. VGA: vga_req.
  3. Sweep write: state SWEEP.
  4. Engine normal: eng_req && !clear_busy.
- The engine is never granted while clear_busy, except through preempt.
- Preempt during SWEEP is allowed only for engine reads. Engine writes wait until the sweep finishes.
- wait_cnt:
  - Increments (saturating at MAX_WAIT) on each cycle eng_req=1 and eng_gnt=0 outside SWEEP.
  - Clears on eng_gnt or !eng_req.
  - Holds during SWEEP.
- vga_miss = 1 in any cycle vga_req=1 and the VGA is not granted; only a preempt can cause this.
- Sweep write:
  - mem_addr = sweep counter {y,x}, mem_we = 1.
  - mem_wdata = 1 when x==0, x==GRID_SIZE-1, y==0 or y==GRID_SIZE-1; otherwise 0.
  - The counter advances only on cycles the sweep wins arbitration.
  - The counter resets to 0 on entry to SWEEP.
- Read return:
  - Latency is exactly 1 cycle.
  - The read-owner register records VGA, ENG or NONE for the access issued this cycle.
  - Next cycle, the matching *_rvalid = 1 and *_rdata = mem_rdata.
  - Writes produce no rvalid.
- Idle cycles: mem_we = 0, mem_addr holds its previous value.
- Engine write then read of the same cell on consecutive grants returns the written value; the RAM is write-first or the read follows in a later cycle.
- Reset mid-sweep: the sweep is abandoned, no clear_done, the RAM contents are undefined until the next clear.
- Simultaneous clear_start and eng_req in IDLE: the engine is granted that cycle if the VGA is idle; the sweep starts the next cycle.

Test Plan:
- Reset, then clear_start with no other traffic -> clear_busy high for 256 cycles, clear_done pulse at cycle 257. Readback: cell (0,5) = 1, (15,3) = 1, (5,0) = 1, (7,7) = 0.
- Engine write (y=8,x=4)=1, then engine read of same address -> eng_gnt each request, eng_rvalid one cycle after the read grant, eng_rdata = 1.
- vga_req held every cycle and eng_req held -> eng_gnt asserts on cycle 9 (after 8 denials), vga_miss pulses that cycle, vga_rvalid is 0 on cycle 10, and the pattern repeats every 9 cycles.
- vga_req every other cycle during a sweep -> the sweep stalls on VGA cycles and completes in 512 cycles. Every VGA read returns the correct value one cycle later.
- Engine write request during SWEEP -> no eng_gnt until the cycle after clear_done, wait_cnt stays frozen, no preempt occurs.
- reset asserted at sweep cycle 100 -> all outputs 0 next cycle, no clear_done. A new clear_start completes a full 256-write sweep.
